pc_stack: RTL and testbench
===========================

PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter WIDTH, default 16, bit width of the program counter and of stack entries.
REQ-002 Parameter DEPTH, default 8, number of return-address stack entries (integer >= 2).
REQ-003 Parameter STEP, default 1, increment applied by inc and used to form the call return address.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in  input  WIDTH  target address for load and call.
REQ-007 load  input  1  jump: out <= in.
REQ-008 inc  input  1  advance: out <= out + STEP.
REQ-009 call  input  1  push out + STEP onto stack, then out <= in.
REQ-010 ret  input  1  pop stack top into out.
REQ-011 hold  input  1  stall: freeze all state.
REQ-012 out  output  WIDTH  current program counter, registered.
REQ-013 top  output  WIDTH  current stack top; 0 when empty.
REQ-014 count  output  $clog2(DEPTH+1)  number of valid stack entries.
REQ-015 full  output  1  count == DEPTH; empty  output  1  count == 0.
REQ-016 err  output  1  sticky stack-fault flag.

Function
REQ-017 Priority per cycle SHALL be reset > hold > ret > call > load > inc > keep; exactly one action per cycle.
REQ-018 All updates SHALL take effect one cycle after the controlling input is sampled; out, count and err SHALL be registered. top, full and empty SHALL be combinational decodes of registered state only.
REQ-019 inc: out <= (out + STEP) mod 2^WIDTH; all-ones + 1 SHALL wrap to 0.
REQ-020 load: out <= in; stack unchanged.
REQ-021 call (not full): stack[count] <= (out + STEP) mod 2^WIDTH, count <= count + 1, out <= in.
REQ-022 ret (not empty): out <= top, count <= count - 1.
REQ-023 ret when empty: out unchanged, count stays 0, err <= 1.
REQ-024 call when full: behaviour SHALL follow REQ-030/REQ-031.
REQ-025 hold: out, count, stack contents and err SHALL remain unchanged regardless of the other inputs.
REQ-026 call and ret asserted together: ret SHALL win; call SHALL be ignored with no push.
REQ-027 err, once set, SHALL remain 1 until reset.

Reset
REQ-028 On reset, out SHALL be 0, count 0, err 0, empty 1, full 0, top 0, overriding all other inputs in that cycle.
REQ-029 Stack storage SHALL NOT require reset; stale entries SHALL never be visible on top or out.

Configuration
REQ-030 With PC_STACK_WRAP_EN defined, the stack SHALL be circular: call when full SHALL overwrite the oldest entry, push the new return address as top, keep count = DEPTH, set out <= in, and leave err unchanged.
REQ-031 Without PC_STACK_WRAP_EN, call when full SHALL be dropped: out, count and stack unchanged, err <= 1.

Verification
REQ-032 Reset, then inc for 3 cycles -> out = 3; inc+load with in=0x0100 -> out = 0x0100 (load beats inc).
REQ-033 out = 0xFFFF, inc -> out = 0x0000, err = 0.
REQ-034 out = 0x0010, call in=0x0200 -> out = 0x0200, top = 0x0011, count = 1; then ret -> out = 0x0011, count = 0, empty = 1.
REQ-035 From reset, ret -> out = 0, err = 1; err stays 1 through 5 further cycles of inc; reset -> err = 0.
REQ-036 DEPTH = 8, 9 consecutive calls from out = 0 with in = 0x0100*k (k = 1..9): wrap build -> count = 8, top = 0x0801, out = 0x0900, err = 0; non-wrap build -> count = 8, top = 0x0701, out = 0x0800, err = 1.
REQ-037 hold with call, ret and inc asserted -> out, count and top unchanged; call+ret together with count = 2 -> single pop, count = 1.

Source files
------------

// File: rtl/pc_stack.sv
// pc_stack: program counter with return-address stack; define PC_STACK_WRAP_EN for a circular stack
module pc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int STEP  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in,
  input  logic                       load,
  input  logic                       inc,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       hold,
  output logic [WIDTH-1:0]           out,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] out_q, out_d, ra;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic             err_q, err_d, do_pop, do_call, do_push, push_err;
  // ptr_q is the next write slot; top lives just below it, modulo DEPTH
  assign ptr_inc = (ptr_q == PW'(DEPTH-1)) ? '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ? PW'(DEPTH-1) : ptr_q - 1'b1;
  assign full    = count_q == CW'(DEPTH);
  assign empty   = count_q == '0;
  assign top     = empty ? '0 : stack_q[ptr_dec];
  assign out     = out_q;
  assign count   = count_q;
  assign err     = err_q;
  // next-state decode in priority order hold > ret > call > load > inc
  always_comb begin
    ra      = out_q + WIDTH'(STEP);
    do_pop  = !hold && ret && !empty;
    do_call = !hold && !ret && call;
`ifdef PC_STACK_WRAP_EN
    do_push  = do_call;
    push_err = 1'b0;
`else
    do_push  = do_call && !full;
    push_err = do_call && full;
`endif
    out_d   = hold ? out_q : ret ? (empty ? out_q : top) : call ? (do_push ? in : out_q) :
              load ? in : inc ? ra : out_q;
    count_d = do_pop ? count_q - 1'b1 : (do_push && !full) ? count_q + 1'b1 : count_q;
    ptr_d   = do_pop ? ptr_dec : do_push ? ptr_inc : ptr_q;
    err_d   = err_q | (!hold && ret && empty) | push_err;
  end
  // control state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      count_q <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end
  // stack storage is never reset; count gates visibility of stale entries
  always_ff @(posedge clk) begin
    if (!reset && do_push) stack_q[ptr_q] <= ra;
  end
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: randomized and directed checks of pc_stack against a queue-based model
module tb_pc_stack;
  localparam int W = 16;
  localparam int D = 8;
  logic clk = 0, reset = 1, load = 0, inc = 0, call = 0, ret = 0, hold = 0;
  logic [W-1:0] in = '0, out, top;
  logic [$clog2(D+1)-1:0] count;
  logic full, empty, err;
  int checks = 0, failures = 0;
  logic [W-1:0] m_out;
  logic [W-1:0] m_q [$];
  logic m_err;

  pc_stack #(.WIDTH(W), .DEPTH(D), .STEP(1)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .inc(inc), .call(call), .ret(ret),
    .hold(hold), .out(out), .top(top), .count(count), .full(full), .empty(empty), .err(err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic h, input logic rt, input logic c,
                      input logic l, input logic i, input logic [W-1:0] a);
    reset = r; hold = h; ret = rt; call = c; load = l; inc = i; in = a;
    @(posedge clk);
    if (r) begin
      m_out = '0; m_q = {}; m_err = 0;
    end else if (h) begin
    end else if (rt) begin
      if (m_q.size() == 0) m_err = 1;
      else m_out = m_q.pop_back();
    end else if (c) begin
      if (m_q.size() < D) begin
        m_q.push_back(W'(m_out + 1)); m_out = a;
      end else begin
`ifdef PC_STACK_WRAP_EN
        void'(m_q.pop_front()); m_q.push_back(W'(m_out + 1)); m_out = a;
`else
        m_err = 1;
`endif
      end
    end else if (l) m_out = a;
    else if (i) m_out = W'(m_out + 1);
    #1;
    chk("out", 32'(out), 32'(m_out));
    chk("count", 32'(count), m_q.size());
    chk("top", 32'(top), m_q.size() ? 32'(m_q[$]) : 0);
    chk("full", 32'(full), 32'(m_q.size() == D));
    chk("empty", 32'(empty), 32'(m_q.size() == 0));
    chk("err", 32'(err), 32'(m_err));
  endtask

  initial begin
    step(1, 0, 1, 1, 1, 1, 16'h1234);
    chk("rst_out", 32'(out), 0);
    chk("rst_empty", 32'(empty), 1);
    repeat (3) step(0, 0, 0, 0, 0, 1, 0);
    chk("inc3", 32'(out), 3);
    step(0, 0, 0, 0, 1, 1, 16'h0100);
    chk("load_beats_inc", 32'(out), 32'h0100);
    step(0, 0, 0, 0, 1, 0, 16'hFFFF);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("wrap_pc", 32'(out), 0);
    chk("wrap_err", 32'(err), 0);
    step(0, 0, 0, 0, 1, 0, 16'h0010);
    step(0, 0, 0, 1, 0, 0, 16'h0200);
    chk("call_out", 32'(out), 32'h0200);
    chk("call_top", 32'(top), 32'h0011);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("ret_out", 32'(out), 32'h0011);
    chk("ret_empty", 32'(empty), 1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("ret_empty_err", 32'(err), 1);
    repeat (5) step(0, 0, 0, 0, 0, 1, 0);
    chk("err_sticky", 32'(err), 1);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("err_cleared", 32'(err), 0);
    for (int k = 1; k <= 9; k++) step(0, 0, 0, 1, 0, 0, W'(16'h0100 * k));
    chk("ovf_count", 32'(count), 8);
`ifdef PC_STACK_WRAP_EN
    chk("ovf_top", 32'(top), 32'h0801);
    chk("ovf_out", 32'(out), 32'h0900);
    chk("ovf_err", 32'(err), 0);
`else
    chk("ovf_top", 32'(top), 32'h0701);
    chk("ovf_out", 32'(out), 32'h0800);
    chk("ovf_err", 32'(err), 1);
`endif
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 16'h0300);
    step(0, 0, 0, 1, 0, 0, 16'h0400);
    step(0, 1, 1, 1, 0, 1, 16'h0555);
    chk("hold_out", 32'(out), 32'h0400);
    chk("hold_top", 32'(top), 32'h0301);
    step(0, 0, 1, 1, 0, 0, 16'h0666);
    chk("callret_count", 32'(count), 1);
    chk("callret_out", 32'(out), 32'h0301);
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 79) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
           ($urandom_range(0, 9) == 0) ? 16'hFFFF : W'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
